ps2_key_matrix: RTL and testbench
=================================

Name: ps2_key_matrix

Overview:
- Consumes PS/2 Set-2 scancodes from the ps2 receiver FIFO: drives its fifo_rd and reads fifo_data, fifo_empty and fifo_overflow.
- Tracks make/break state in a 6x8 key matrix matching the Videopac console keyboard.
- The CPU keyboard scan selects a row and reads that row's column bits, active-low.
- Sits between the ps2 receiver and the CPU port-read logic. It replaces ad-hoc per-key decoding.

Parameters:
- NUM_ROWS, 6, number of matrix rows; row_sel values >= NUM_ROWS read as all-released.
- PAUSE_SKIP, 7, number of bytes discarded after an E1 prefix (Pause sequence).

Ports:
- clock_27mhz  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- fifo_data  in  8  scancode at the receiver FIFO head; valid while fifo_empty=0.
- fifo_empty  in  1  receiver FIFO empty.
- fifo_overflow  in  1  receiver overflow flag.
- fifo_rd  out  1  pop request, one cycle per byte consumed.
- row_sel  in  3  CPU keyboard row select.
- col_out  out  8  active-low column bits for the selected row (0 = pressed).
- key_event  out  1  one-cycle pulse after a mapped key changes matrix state.
- any_key  out  1  high while any matrix bit is set.

Behaviour:
- Reset (reset=0, asynchronous): clear matrix, brk, ext and skip_cnt; FSM goes to FETCH. Outputs: fifo_rd=0, key_event=0, any_key=0, col_out=8'hFF.
- FSM states: FETCH, DECODE.
- FETCH: if fifo_empty=0, then:
  - assert fifo_rd for this cycle;
  - latch fifo_data into code_q on the same edge;
  - go to DECODE.
  - Otherwise stay in FETCH with fifo_rd=0.
- DECODE: always returns to FETCH the next cycle. fifo_rd is never high two cycles in a row, so peak throughput is 1 byte per 2 cycles.
- DECODE priority, evaluated in this order:
  1. skip_cnt != 0: decrement it and ignore the byte.
  2. code_q == F0: brk <= 1.
  3. code_q == E0: ext <= 1.
  4. code_q == E1: skip_cnt <= PAUSE_SKIP; clear brk and ext.
  5. Otherwise: look up {ext, code_q} in the package map.
     - Hit: matrix[row][col] <= ~brk, and pulse key_event next cycle, even if the bit already held that value.
     - Miss: no matrix change, no pulse.
     - In both cases clear brk and ext.
- Prefix state persists across FETCH idle periods for any length of time.
- col_out is combinational from registered state:
  - row_sel < NUM_ROWS: col_out = ~matrix[row_sel].
  - otherwise: col_out = 8'hFF.
- any_key = OR of all matrix bits, registered (one cycle behind matrix).
- fifo_overflow=1 in any cycle: clear matrix, brk, ext and skip_cnt. This prevents stuck keys after lost break codes.
  - If a DECODE coincides with fifo_overflow=1, overflow wins and the decoded byte is dropped. No key_event is generated.
- Typematic repeat (repeated make codes) re-sets an already-set bit and still pulses key_event.
- Reset mid-prefix or mid-skip discards the partial sequence.

Decomposition:
- Package ps2_kbd_pkg holds:
  - constants SC_BREAK=8'hF0, SC_EXT=8'hE0, SC_PAUSE=8'hE1;
  - function kmap(ext, code), returning {hit, row[2:0], col[2:0]}.
- Required kmap entries:
  - 45->r0c0 ('0'), 16->r0c1 ('1'), 1E->r0c2 ('2');
  - 29->r1c4 (space), 1C->r3c6 ('A');
  - 5A->r5c6 (Enter); E0+5A->r5c6 (keypad Enter aliases Enter).
  - All other console keys are defined in the same package table.
- The module contains no sub-module; the FSM and matrix are small enough to stay in one module.

Test Plan:
- After reset, FIFO holds 16: fifo_rd pulses once; key_event pulses. With row_sel=0: col_out=8'hFD, any_key=1.
- Then push F0,16: after the 2nd byte decodes, row_sel=0 gives col_out=8'hFF, any_key=0, and exactly one key_event occurs across both bytes.
- Push E0,5A then F0,5A (back-to-back in FIFO): row_sel=5 gives col_out=8'hBF after the make and 8'hFF after the break. fifo_rd is never high on consecutive cycles.
- Push the Pause sequence E1 14 77 E1 F0 14 F0 77 followed by 1C: no key_event for the 8 pause bytes; then row_sel=3 gives col_out=8'hBF.
- Press 1C and 29, then assert fifo_overflow for 1 cycle: row 3 and row 1 read 8'hFF, any_key=0. If a DECODE coincides with the overflow, its byte has no effect.
- row_sel=6 or 7 with keys held gives col_out=8'hFF. Pulling reset low while brk is set, then pushing 16 after release, gives a press (col_out row0=8'hFD), not a release.

Source files
------------

// File: rtl/ps2_kbd_pkg.sv
// Shared constants, types and the Set-2 scancode to Videopac key-matrix map.
package ps2_kbd_pkg;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_PAUSE = 8'hE1;

  localparam int unsigned COL_W = 8;

  typedef enum logic {
    ST_FETCH,
    ST_DECODE
  } kbd_state_t;

  typedef struct packed {
    logic       hit;
    logic [2:0] row;
    logic [2:0] col;
  } kmap_t;

  function automatic kmap_t key_at(input logic [2:0] r, input logic [2:0] c);
    kmap_t k;
    k.hit = 1'b1;
    k.row = r;
    k.col = c;
    return k;
  endfunction

  // {ext, code} -> matrix position; anything not listed is not a console key.
  function automatic kmap_t kmap(input logic ext, input logic [7:0] code);
    kmap_t k;
    k = '0;
    case ({ext, code})
      // row 0: digits 0..7
      9'h045: k = key_at(3'd0, 3'd0);
      9'h016: k = key_at(3'd0, 3'd1);
      9'h01E: k = key_at(3'd0, 3'd2);
      9'h026: k = key_at(3'd0, 3'd3);
      9'h025: k = key_at(3'd0, 3'd4);
      9'h02E: k = key_at(3'd0, 3'd5);
      9'h036: k = key_at(3'd0, 3'd6);
      9'h03D: k = key_at(3'd0, 3'd7);
      // row 1: 8 9 ; ' space ? L P
      9'h03E: k = key_at(3'd1, 3'd0);
      9'h046: k = key_at(3'd1, 3'd1);
      9'h04C: k = key_at(3'd1, 3'd2);
      9'h052: k = key_at(3'd1, 3'd3);
      9'h029: k = key_at(3'd1, 3'd4);
      9'h04A: k = key_at(3'd1, 3'd5);
      9'h04B: k = key_at(3'd1, 3'd6);
      9'h04D: k = key_at(3'd1, 3'd7);
      // row 2: + W E R T U I O
      9'h079: k = key_at(3'd2, 3'd0);
      9'h01D: k = key_at(3'd2, 3'd1);
      9'h024: k = key_at(3'd2, 3'd2);
      9'h02D: k = key_at(3'd2, 3'd3);
      9'h02C: k = key_at(3'd2, 3'd4);
      9'h03C: k = key_at(3'd2, 3'd5);
      9'h043: k = key_at(3'd2, 3'd6);
      9'h044: k = key_at(3'd2, 3'd7);
      // row 3: Q S D F G H A J
      9'h015: k = key_at(3'd3, 3'd0);
      9'h01B: k = key_at(3'd3, 3'd1);
      9'h023: k = key_at(3'd3, 3'd2);
      9'h02B: k = key_at(3'd3, 3'd3);
      9'h034: k = key_at(3'd3, 3'd4);
      9'h033: k = key_at(3'd3, 3'd5);
      9'h01C: k = key_at(3'd3, 3'd6);
      9'h03B: k = key_at(3'd3, 3'd7);
      // row 4: Z X C V B M . -
      9'h01A: k = key_at(3'd4, 3'd0);
      9'h022: k = key_at(3'd4, 3'd1);
      9'h021: k = key_at(3'd4, 3'd2);
      9'h02A: k = key_at(3'd4, 3'd3);
      9'h032: k = key_at(3'd4, 3'd4);
      9'h03A: k = key_at(3'd4, 3'd5);
      9'h049: k = key_at(3'd4, 3'd6);
      9'h04E: k = key_at(3'd4, 3'd7);
      // row 5: K Y N * = clear enter escape
      9'h042: k = key_at(3'd5, 3'd0);
      9'h035: k = key_at(3'd5, 3'd1);
      9'h031: k = key_at(3'd5, 3'd2);
      9'h07C: k = key_at(3'd5, 3'd3);
      9'h055: k = key_at(3'd5, 3'd4);
      9'h066: k = key_at(3'd5, 3'd5);
      9'h05A: k = key_at(3'd5, 3'd6);
      9'h076: k = key_at(3'd5, 3'd7);
      // keypad Enter shares the console Enter position
      9'h15A: k = key_at(3'd5, 3'd6);
      default: k = '0;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/ps2_key_matrix.sv
// Pops Set-2 scancodes from the PS/2 receiver FIFO and keeps the Videopac
// key matrix up to date for the CPU's row-select / column-read scan.
module ps2_key_matrix
  import ps2_kbd_pkg::*;
#(
  parameter int unsigned NUM_ROWS   = 6,
  parameter int unsigned PAUSE_SKIP = 7
) (
  input  logic       clock_27mhz,
  input  logic       reset,
  input  logic [7:0] fifo_data,
  input  logic       fifo_empty,
  input  logic       fifo_overflow,
  output logic       fifo_rd,
  input  logic [2:0] row_sel,
  output logic [7:0] col_out,
  output logic       key_event,
  output logic       any_key
);

  localparam int unsigned SKIP_W    = $clog2(PAUSE_SKIP + 1);
  localparam logic [3:0]  ROW_LIMIT = 4'(NUM_ROWS);

  kbd_state_t                       state;
  logic [7:0]                       code_q;
  logic                             brk;
  logic                             ext;
  logic [SKIP_W-1:0]                skip_cnt;
  logic [NUM_ROWS-1:0][COL_W-1:0]   matrix;
  kmap_t                            map;

  assign map     = kmap(ext, code_q);
  // Pop strobe coincides with the edge that latches the head byte.
  assign fifo_rd = (state == ST_FETCH) && !fifo_empty;

  always_ff @(posedge clock_27mhz or negedge reset) begin
    if (!reset) begin
      state     <= ST_FETCH;
      code_q    <= '0;
      brk       <= 1'b0;
      ext       <= 1'b0;
      skip_cnt  <= '0;
      matrix    <= '0;
      key_event <= 1'b0;
      any_key   <= 1'b0;
    end else begin
      key_event <= 1'b0;
      any_key   <= |matrix;

      case (state)
        ST_FETCH: begin
          if (!fifo_empty) begin
            code_q <= fifo_data;
            state  <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          state <= ST_FETCH;
          if (skip_cnt != '0) begin
            skip_cnt <= skip_cnt - SKIP_W'(1);
          end else if (code_q == SC_BREAK) begin
            brk <= 1'b1;
          end else if (code_q == SC_EXT) begin
            ext <= 1'b1;
          end else if (code_q == SC_PAUSE) begin
            skip_cnt <= SKIP_W'(PAUSE_SKIP);
            brk      <= 1'b0;
            ext      <= 1'b0;
          end else begin
            brk <= 1'b0;
            ext <= 1'b0;
            if (map.hit && ({1'b0, map.row} < ROW_LIMIT)) begin
              matrix[map.row][map.col] <= ~brk;
              key_event                <= 1'b1;
            end
          end
        end
        default: state <= ST_FETCH;
      endcase

      // Overflow means break codes may have been lost: release everything.
      if (fifo_overflow) begin
        matrix    <= '0;
        brk       <= 1'b0;
        ext       <= 1'b0;
        skip_cnt  <= '0;
        key_event <= 1'b0;
      end
    end
  end

  // Active-low column read; rows outside the matrix read as all-released.
  always_comb begin
    col_out = 8'hFF;
    if ({1'b0, row_sel} < ROW_LIMIT) begin
      col_out = ~matrix[row_sel];
    end
  end

endmodule

// File: tb/tb_ps2_key_matrix.sv
// Bench for ps2_key_matrix: FIFO model feeding scancodes, byte-stream
// reference model of the keyboard protocol, directed and random scenarios.
module tb_ps2_key_matrix;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] fifo_data;
  logic       fifo_empty;
  logic       fifo_overflow;
  logic       fifo_rd;
  logic [2:0] row_sel;
  logic [7:0] col_out;
  logic       key_event;
  logic       any_key;

  ps2_key_matrix dut (
    .clock_27mhz  (clk),
    .reset        (reset),
    .fifo_data    (fifo_data),
    .fifo_empty   (fifo_empty),
    .fifo_overflow(fifo_overflow),
    .fifo_rd      (fifo_rd),
    .row_sel      (row_sel),
    .col_out      (col_out),
    .key_event    (key_event),
    .any_key      (any_key)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0] q[$];
  bit  rd_now    = 1'b0;
  int  ke_cnt    = 0;
  int  rd_cnt    = 0;
  int  rd_consec = 0;

  // Reference keyboard state: which keys are down, plus pending prefixes.
  bit m_key[6][8];
  bit m_brk;
  bit m_ext;
  int m_skip;
  int m_events = 0;

  // Key positions known from the keyboard description; -1 = not a console key.
  function automatic int ref_map(input bit e, input logic [7:0] c);
    if (e) return (c == 8'h5A) ? 5 * 8 + 6 : -1;
    case (c)
      8'h45:   return 0 * 8 + 0;
      8'h16:   return 0 * 8 + 1;
      8'h1E:   return 0 * 8 + 2;
      8'h29:   return 1 * 8 + 4;
      8'h1C:   return 3 * 8 + 6;
      8'h5A:   return 5 * 8 + 6;
      default: return -1;
    endcase
  endfunction

  function automatic logic [7:0] exp_col(input int r);
    logic [7:0] v;
    v = 8'hFF;
    if (r < 6) for (int c = 0; c < 8; c++) if (m_key[r][c]) v[c] = 1'b0;
    return v;
  endfunction

  function automatic bit exp_any();
    for (int r = 0; r < 6; r++) for (int c = 0; c < 8; c++) if (m_key[r][c]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic m_clear();
    for (int r = 0; r < 6; r++) for (int c = 0; c < 8; c++) m_key[r][c] = 1'b0;
    m_brk = 1'b0; m_ext = 1'b0; m_skip = 0;
  endtask

  // Feed one byte to both the reference model and the FIFO.
  task automatic push(input logic [7:0] b);
    int idx;
    if (m_skip > 0) m_skip--;
    else if (b == 8'hF0) m_brk = 1'b1;
    else if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hE1) begin m_skip = 7; m_brk = 1'b0; m_ext = 1'b0; end
    else begin
      idx = ref_map(m_ext, b);
      if (idx >= 0) begin m_key[idx / 8][idx % 8] = !m_brk; m_events++; end
      m_brk = 1'b0; m_ext = 1'b0;
    end
    q.push_back(b);
  endtask

  task automatic tick();
    @(posedge clk); #1;
    if (rd_now && q.size() != 0) q.delete(0);
    ke_cnt += int'(key_event);
    fifo_empty = (q.size() == 0);
    fifo_data  = (q.size() != 0) ? q[0] : 8'h00;
    #1;
    rd_cnt += int'(fifo_rd);
    if (fifo_rd && rd_now) rd_consec++;
    rd_now = fifo_rd;
  endtask

  task automatic drain();
    for (int i = 0; i < 500 && q.size() != 0; i++) tick();
    repeat (4) tick();
    total++;
    if (q.size() !== 0) begin
      bad++;
      $display("FAIL drain_timeout: left=%0d required=0", q.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; fifo_overflow = 1'b0; fifo_empty = 1'b1; fifo_data = 8'h00; row_sel = 3'd0;
    q.delete(); rd_now = 1'b0; m_clear();
    #2;
    total++; if (fifo_rd !== 1'b0)   begin bad++; $display("FAIL reset_fifo_rd: got=%b want=0", fifo_rd); end
    total++; if (key_event !== 1'b0) begin bad++; $display("FAIL reset_key_event: got=%b want=0", key_event); end
    total++; if (any_key !== 1'b0)   begin bad++; $display("FAIL reset_any_key: got=%b want=0", any_key); end
    total++; if (col_out !== 8'hFF)  begin bad++; $display("FAIL reset_col_out: got=%h want=ff", col_out); end
    tick(); tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_press();
    int rd0 = rd_cnt, ke0 = ke_cnt;
    push(8'h16);
    drain();
    row_sel = 3'd0; #1;
    total++; if (rd_cnt - rd0 !== 1) begin bad++; $display("FAIL press_rd_pulses: got=%0d want=1", rd_cnt - rd0); end
    total++; if (ke_cnt - ke0 !== 1) begin bad++; $display("FAIL press_events: got=%0d want=1", ke_cnt - ke0); end
    total++; if (col_out !== 8'hFD)  begin bad++; $display("FAIL press_row0: got=%h want=fd", col_out); end
    total++; if (any_key !== 1'b1)   begin bad++; $display("FAIL press_any_key: got=%b want=1", any_key); end
  endtask

  task automatic test_release();
    int ke0 = ke_cnt;
    push(8'hF0); push(8'h16);
    drain();
    row_sel = 3'd0; #1;
    total++; if (col_out !== 8'hFF)  begin bad++; $display("FAIL release_row0: got=%h want=ff", col_out); end
    total++; if (any_key !== 1'b0)   begin bad++; $display("FAIL release_any_key: got=%b want=0", any_key); end
    total++; if (ke_cnt - ke0 !== 1) begin bad++; $display("FAIL release_events: got=%0d want=1", ke_cnt - ke0); end
  endtask

  task automatic test_back_to_back();
    bit seen = 1'b0;
    int c0 = rd_consec;
    row_sel = 3'd5;
    push(8'hE0); push(8'h5A); push(8'hF0); push(8'h5A);
    for (int i = 0; i < 60 && !seen; i++) begin
      tick();
      if (key_event) begin
        seen = 1'b1;
        total++; if (col_out !== 8'hBF) begin bad++; $display("FAIL b2b_make_row5: got=%h want=bf", col_out); end
      end
    end
    total++; if (!seen) begin bad++; $display("FAIL b2b_make_event: got=none want=pulse"); end
    drain();
    #1;
    total++; if (col_out !== 8'hFF)     begin bad++; $display("FAIL b2b_break_row5: got=%h want=ff", col_out); end
    total++; if (rd_consec - c0 !== 0)  begin bad++; $display("FAIL b2b_rd_consecutive: got=%0d want=0", rd_consec - c0); end
    total++; if (ke_cnt !== m_events)   begin bad++; $display("FAIL b2b_events: got=%0d want=%0d", ke_cnt, m_events); end
  endtask

  task automatic test_pause();
    logic [7:0] seq[8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    int ke0 = ke_cnt;
    foreach (seq[i]) push(seq[i]);
    drain();
    total++; if (ke_cnt - ke0 !== 0) begin bad++; $display("FAIL pause_events: got=%0d want=0", ke_cnt - ke0); end
    push(8'h1C);
    drain();
    row_sel = 3'd3; #1;
    total++; if (col_out !== 8'hBF)  begin bad++; $display("FAIL pause_then_a: got=%h want=bf", col_out); end
    total++; if (ke_cnt - ke0 !== 1) begin bad++; $display("FAIL pause_then_a_events: got=%0d want=1", ke_cnt - ke0); end
  endtask

  task automatic test_overflow();
    push(8'h1C); push(8'h29);
    drain();
    row_sel = 3'd1; #1;
    total++; if (col_out !== 8'hEF) begin bad++; $display("FAIL ovf_pre_row1: got=%h want=ef", col_out); end
    fifo_overflow = 1'b1; tick(); fifo_overflow = 1'b0; m_clear();
    tick(); tick();
    row_sel = 3'd3; #1;
    total++; if (col_out !== 8'hFF) begin bad++; $display("FAIL ovf_row3: got=%h want=ff", col_out); end
    row_sel = 3'd1; #1;
    total++; if (col_out !== 8'hFF) begin bad++; $display("FAIL ovf_row1: got=%h want=ff", col_out); end
    total++; if (any_key !== 1'b0)  begin bad++; $display("FAIL ovf_any_key: got=%b want=0", any_key); end
    // The decoded byte lands in the overflow cycle, so the model never sees it.
    q.push_back(8'h1C);
    for (int i = 0; i < 20 && !rd_now; i++) tick();
    total++; if (!rd_now) begin bad++; $display("FAIL ovf_pop_timeout: got=no_pop want=pop"); end
    tick();
    fifo_overflow = 1'b1; tick(); fifo_overflow = 1'b0;
    total++; if (key_event !== 1'b0) begin bad++; $display("FAIL ovf_drop_event: got=%b want=0", key_event); end
    repeat (3) tick();
    row_sel = 3'd3; #1;
    total++; if (col_out !== 8'hFF)  begin bad++; $display("FAIL ovf_drop_row3: got=%h want=ff", col_out); end
    total++; if (ke_cnt !== m_events) begin bad++; $display("FAIL ovf_events: got=%0d want=%0d", ke_cnt, m_events); end
  endtask

  task automatic test_rows_and_reset_prefix();
    push(8'h45); push(8'h5A);
    drain();
    row_sel = 3'd0; #1;
    total++; if (col_out !== 8'hFE) begin bad++; $display("FAIL held_row0: got=%h want=fe", col_out); end
    for (int r = 6; r < 8; r++) begin
      row_sel = 3'(r); #1;
      total++; if (col_out !== 8'hFF) begin bad++; $display("FAIL oor_row%0d: got=%h want=ff", r, col_out); end
    end
    push(8'hF0);
    drain();
    reset = 1'b0; q.delete(); rd_now = 1'b0; m_clear();
    tick(); tick();
    reset = 1'b1;
    tick();
    push(8'h16);
    drain();
    row_sel = 3'd0; #1;
    total++; if (col_out !== 8'hFD) begin bad++; $display("FAIL reset_prefix_row0: got=%h want=fd", col_out); end
  endtask

  task automatic test_random();
    bit         ke[7]   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [7:0] kc[7]   = '{8'h45, 8'h16, 8'h1E, 8'h29, 8'h1C, 8'h5A, 8'h5A};
    int unsigned act, k;
    for (int it = 0; it < 60; it++) begin
      act = $urandom_range(0, 9);
      k   = $urandom_range(0, 6);
      if (act <= 4) begin
        if (ke[k]) push(8'hE0);
        push(kc[k]);
      end else if (act <= 7) begin
        if (ke[k]) push(8'hE0);
        push(8'hF0); push(kc[k]);
      end else if (act == 8) begin
        if ($urandom_range(0, 1) != 0) push(8'h07);
        else begin push(8'hE0); push(8'h16); end
      end else begin
        push(8'hE1); push(8'h14); push(8'h77); push(8'hE1);
        push(8'hF0); push(8'h14); push(8'hF0); push(8'h77);
      end
      repeat ($urandom_range(0, 3)) tick();
      if (it % 5 == 4) begin
        drain();
        for (int r = 0; r < 8; r++) begin
          row_sel = 3'(r); #1;
          total++;
          if (col_out !== exp_col(r)) begin
            bad++; $display("FAIL rand_it%0d_row%0d: got=%h want=%h", it, r, col_out, exp_col(r));
          end
        end
        total++; if (any_key !== exp_any())  begin bad++; $display("FAIL rand_it%0d_any: got=%b want=%b", it, any_key, exp_any()); end
        total++; if (ke_cnt !== m_events)    begin bad++; $display("FAIL rand_it%0d_events: got=%0d want=%0d", it, ke_cnt, m_events); end
        if (it % 10 == 9) begin
          fifo_overflow = 1'b1; tick(); fifo_overflow = 1'b0; m_clear();
          tick(); tick();
          total++; if (any_key !== 1'b0) begin bad++; $display("FAIL rand_it%0d_ovf_any: got=%b want=0", it, any_key); end
        end
      end
    end
    total++; if (rd_consec !== 0) begin bad++; $display("FAIL rand_rd_consecutive: got=%0d want=0", rd_consec); end
  endtask

  initial begin
    test_reset();
    test_press();
    test_release();
    test_back_to_back();
    test_pause();
    test_overflow();
    test_rows_and_reset_prefix();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
